// File: rtl/payload_match_sched_if.sv
// Handshake and engine-bank bundle for payload_match_sched: payload byte
// stream, shared engine control, match vector and the alert report channel.
interface payload_match_sched_if #(
    parameter int NUM_ENG = 64,
    parameter int ID_W    = 6
);
    logic               byte_valid;
    logic               byte_sop;
    logic               byte_eop;
    logic               byte_ready;
    logic               eng_sod;
    logic               eng_en;
    logic               eng_char_valid;
    logic [NUM_ENG-1:0] eng_match;
    logic               rpt_valid;
    logic               rpt_ready;
    logic [ID_W-1:0]    rpt_id;
    logic               rpt_none;
    logic               rpt_last;
    logic [15:0]        pkt_cnt;

    modport master (
        output byte_valid, byte_sop, byte_eop, eng_match, rpt_ready,
        input  byte_ready, eng_sod, eng_en, eng_char_valid,
               rpt_valid, rpt_id, rpt_none, rpt_last, pkt_cnt
    );

    modport slave (
        input  byte_valid, byte_sop, byte_eop, eng_match, rpt_ready,
        output byte_ready, eng_sod, eng_en, eng_char_valid,
               rpt_valid, rpt_id, rpt_none, rpt_last, pkt_cnt
    );
endinterface

// File: rtl/payload_match_sched.sv
// Per-packet sequencer for the payload pattern engine bank: clear, scan, flush,
// capture the match vector, then serialize matching engine IDs to the alert path.
module payload_match_sched #(
    parameter int NUM_ENG   = 64,
    parameter int ID_W      = 6,
    parameter int FLUSH_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    payload_match_sched_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        SCAN    = 3'd2,
        FLUSH   = 3'd3,
        CAPTURE = 3'd4,
        DRAIN   = 3'd5
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [3:0]         flush_cnt_r;
    logic [NUM_ENG-1:0] pend_r;
    logic [NUM_ENG-1:0] pend_next_s;
    logic               eng_sod_r;
    logic               rpt_valid_r;
    logic [ID_W-1:0]    rpt_id_r;
    logic               rpt_none_r;
    logic               rpt_last_r;
    logic [15:0]        pkt_cnt_r;
    logic               hs_s;
    logic               byte_ready_s;
    logic               eng_en_s;
    logic               eng_char_valid_s;

    // Index of the lowest set bit; zero for an empty vector.
    function automatic logic [ID_W-1:0] lowest_id(input logic [NUM_ENG-1:0] v);
        logic [ID_W-1:0] id;
        id = {ID_W{1'b0}};
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (v[i]) begin
                id = ID_W'(i);
            end
        end
        return id;
    endfunction

    // True when at most one bit is set.
    function automatic logic at_most_one(input logic [NUM_ENG-1:0] v);
        return (v & (v - NUM_ENG'(1))) == {NUM_ENG{1'b0}};
    endfunction

    assign hs_s        = rpt_valid_r & bus.rpt_ready;
    assign pend_next_s = pend_r & (pend_r - NUM_ENG'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    if (bus.byte_valid && bus.byte_sop) next_state_s = CLEAR; else next_state_s = IDLE;
            CLEAR:   next_state_s = SCAN;
            SCAN:    if (bus.byte_valid && bus.byte_eop) next_state_s = FLUSH; else next_state_s = SCAN;
            FLUSH:   if (flush_cnt_r <= 4'd1) next_state_s = CAPTURE; else next_state_s = FLUSH;
            CAPTURE: next_state_s = DRAIN;
            DRAIN:   if (hs_s && rpt_last_r) next_state_s = IDLE; else next_state_s = DRAIN;
            default: next_state_s = IDLE;
        endcase
    end

    // Combinational handshake and engine strobes, forced low during reset.
    always_comb begin
        byte_ready_s     = 1'b0;
        eng_en_s         = 1'b0;
        eng_char_valid_s = 1'b0;
        if (rst) begin
            byte_ready_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: byte_ready_s = bus.byte_valid & ~bus.byte_sop;
                SCAN: begin
                    byte_ready_s     = 1'b1;
                    eng_en_s         = bus.byte_valid;
                    eng_char_valid_s = bus.byte_valid;
                end
                FLUSH:   eng_en_s = 1'b1;
                default: byte_ready_s = 1'b0;
            endcase
        end
    end

    // Flush down-counter, loaded as the eop byte is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_r <= 4'd0;
        end else if (state_r == SCAN && bus.byte_valid && bus.byte_eop) begin
            flush_cnt_r <= 4'(FLUSH_CYC);
        end else if (state_r == FLUSH && flush_cnt_r != 4'd0) begin
            flush_cnt_r <= flush_cnt_r - 4'd1;
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    // Engine clear pulse; held high through reset so the bank starts cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_sod_r <= 1'b1;
        end else begin
            eng_sod_r <= (next_state_s == CLEAR);
        end
    end

    // Pending matches and the registered report record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r      <= {NUM_ENG{1'b0}};
            rpt_valid_r <= 1'b0;
            rpt_id_r    <= {ID_W{1'b0}};
            rpt_none_r  <= 1'b0;
            rpt_last_r  <= 1'b0;
        end else if (state_r == CAPTURE) begin
            pend_r      <= bus.eng_match;
            rpt_valid_r <= 1'b1;
            rpt_id_r    <= lowest_id(bus.eng_match);
            rpt_none_r  <= (bus.eng_match == {NUM_ENG{1'b0}});
            rpt_last_r  <= at_most_one(bus.eng_match);
        end else if (state_r == DRAIN && hs_s) begin
            pend_r <= pend_next_s;
            if (rpt_last_r) begin
                rpt_valid_r <= 1'b0;
            end else begin
                rpt_id_r   <= lowest_id(pend_next_s);
                rpt_none_r <= 1'b0;
                rpt_last_r <= at_most_one(pend_next_s);
            end
        end else begin
            pend_r <= pend_r;
        end
    end

    // Completed-packet counter, bumped on the final report handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_r <= 16'd0;
        end else if (state_r == DRAIN && hs_s && rpt_last_r) begin
            pkt_cnt_r <= pkt_cnt_r + 16'd1;
        end else begin
            pkt_cnt_r <= pkt_cnt_r;
        end
    end

    assign bus.byte_ready     = byte_ready_s;
    assign bus.eng_en         = eng_en_s;
    assign bus.eng_char_valid = eng_char_valid_s;
    assign bus.eng_sod        = eng_sod_r;
    assign bus.rpt_valid      = rpt_valid_r;
    assign bus.rpt_id         = rpt_id_r;
    assign bus.rpt_none       = rpt_none_r;
    assign bus.rpt_last       = rpt_last_r;
    assign bus.pkt_cnt        = pkt_cnt_r;
endmodule

// File: tb/tb_payload_match_sched.sv
// Directed bench for payload_match_sched with hand-computed expectations.
`timescale 1ns/1ps
module tb_payload_match_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    payload_match_sched_if #(.NUM_ENG(64), .ID_W(6)) bus ();

    payload_match_sched #(.NUM_ENG(64), .ID_W(6), .FLUSH_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vec  = 0;
    int errs = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // results of the last drain() call
    logic [5:0] r_id [8];
    bit         r_none [8];
    bit         r_last [8];
    int         r_n, r_first, r_lasths, r_unstable, r_brbad;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed an n-byte packet; optionally drop byte_valid once before byte gap_at.
    task automatic send_pkt(input int n, input logic [63:0] match, input int gap_at,
                            output int sod_cnt, output int sod_ok, output int stall_bad,
                            output int stall_seen, output int eop_cyc);
        int i;
        int guard;
        bit gapped;
        i = 0; guard = 0; gapped = 0;
        sod_cnt = 0; sod_ok = 0; stall_bad = 0; stall_seen = 0; eop_cyc = -1;
        bus.eng_match = match;
        while (i < n && guard < 100) begin
            if (i == gap_at && !gapped) begin
                bus.byte_valid = 1'b0;
                gapped = 1;
            end else begin
                bus.byte_valid = 1'b1;
            end
            bus.byte_sop = (i == 0);
            bus.byte_eop = (i == n - 1);
            @(negedge clk);
            if (bus.eng_sod) sod_cnt++;
            if (!bus.byte_valid) begin
                stall_seen++;
                if (bus.eng_en || bus.eng_char_valid) stall_bad++;
            end
            if (bus.byte_valid && bus.byte_ready) begin
                if (i == 0) sod_ok = (sod_cnt == 1);
                if (i == n - 1) eop_cyc = cyc;
                i++;
            end
            guard++;
            tick();
        end
        bus.byte_valid = 1'b0;
        bus.byte_sop   = 1'b0;
        bus.byte_eop   = 1'b0;
    endtask

    // Collect report records until the last one (or max_hs handshakes).
    task automatic drain(input bit toggle, input bit hold_sop, input int max_hs);
        bit pv, pr, pn, pl;
        logic [5:0] pid;
        int hs;
        r_n = 0; r_first = -1; r_lasths = -1; r_unstable = 0; r_brbad = 0;
        pv = 0; pr = 1; pn = 0; pl = 0; pid = 6'd0; hs = 0;
        for (int k = 0; k < 60; k++) begin
            bus.rpt_ready = toggle ? (k % 2 == 0) : 1'b1;
            if (hold_sop) begin
                bus.byte_valid = 1'b1;
                bus.byte_sop   = 1'b1;
                bus.byte_eop   = 1'b1;
            end
            @(negedge clk);
            if (hold_sop && bus.byte_ready) r_brbad++;
            if (pv && !pr && (!bus.rpt_valid || bus.rpt_id !== pid ||
                              bus.rpt_none !== pn || bus.rpt_last !== pl)) r_unstable++;
            if (bus.rpt_valid && r_first < 0) r_first = cyc;
            pv = bus.rpt_valid; pr = bus.rpt_ready; pid = bus.rpt_id;
            pn = bus.rpt_none;  pl = bus.rpt_last;
            if (bus.rpt_valid && bus.rpt_ready) begin
                if (r_n < 8) begin
                    r_id[r_n]   = bus.rpt_id;
                    r_none[r_n] = bus.rpt_none;
                    r_last[r_n] = bus.rpt_last;
                end
                r_n++;
                hs++;
                if (bus.rpt_last) r_lasths = cyc;
            end
            tick();
            if (r_lasths >= 0 || hs >= max_hs) break;
        end
        bus.rpt_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.byte_valid = 1'b1; bus.byte_sop = 1'b0; bus.byte_eop = 1'b0;
        bus.rpt_ready = 1'b1; bus.eng_match = 64'h0;
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        vec++; if (bus.eng_sod !== 1'b1) begin errs++; $display("FAIL rst_sod got=%0b exp=1", bus.eng_sod); end
        vec++; if (bus.byte_ready !== 1'b0) begin errs++; $display("FAIL rst_byte_ready got=%0b exp=0", bus.byte_ready); end
        vec++; if (bus.rpt_valid !== 1'b0) begin errs++; $display("FAIL rst_rpt_valid got=%0b exp=0", bus.rpt_valid); end
        vec++; if (bus.pkt_cnt !== 16'd0) begin errs++; $display("FAIL rst_pkt_cnt got=%0d exp=0", bus.pkt_cnt); end
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        vec++; if (bus.eng_sod !== 1'b0) begin errs++; $display("FAIL rel_sod got=%0b exp=0", bus.eng_sod); end
        vec++; if (bus.byte_ready !== 1'b1) begin errs++; $display("FAIL idle_discard got=%0b exp=1", bus.byte_ready); end
        tick();
        bus.byte_valid = 1'b0;
        bus.rpt_ready  = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int sc, so, sb, ss, ec;
        send_pkt(10, 64'h8, -1, sc, so, sb, ss, ec);
        drain(1'b0, 1'b0, 99);
        vec++; if (sc !== 1) begin errs++; $display("FAIL single_sod_pulses got=%0d exp=1", sc); end
        vec++; if (so !== 1) begin errs++; $display("FAIL single_sod_before_byte got=%0d exp=1", so); end
        vec++; if (r_n !== 1) begin errs++; $display("FAIL single_nrec got=%0d exp=1", r_n); end
        vec++; if (r_id[0] !== 6'd3 || r_last[0] !== 1'b1 || r_none[0] !== 1'b0) begin errs++;
            $display("FAIL single_rec got id=%0d last=%0b none=%0b exp id=3 last=1 none=0", r_id[0], r_last[0], r_none[0]); end
        vec++; if (ec < 0 || r_first - ec !== 4) begin errs++; $display("FAIL single_latency got=%0d exp=4", r_first - ec); end
        vec++; if (bus.pkt_cnt !== 16'd1) begin errs++; $display("FAIL single_pkt_cnt got=%0d exp=1", bus.pkt_cnt); end
    endtask

    task automatic test_multi_bp();
        int sc, so, sb, ss, ec;
        send_pkt(5, 64'h8000_0000_0000_0021, -1, sc, so, sb, ss, ec);
        drain(1'b1, 1'b0, 99);
        vec++; if (r_n !== 3) begin errs++; $display("FAIL multi_nrec got=%0d exp=3", r_n); end
        vec++; if (r_id[0] !== 6'd0 || r_id[1] !== 6'd5 || r_id[2] !== 6'd63) begin errs++;
            $display("FAIL multi_ids got=%0d,%0d,%0d exp=0,5,63", r_id[0], r_id[1], r_id[2]); end
        vec++; if (r_last[0] !== 1'b0 || r_last[1] !== 1'b0 || r_last[2] !== 1'b1) begin errs++;
            $display("FAIL multi_last got=%0b%0b%0b exp=001", r_last[0], r_last[1], r_last[2]); end
        vec++; if (r_unstable !== 0) begin errs++; $display("FAIL multi_stable got=%0d exp=0", r_unstable); end
        vec++; if (bus.pkt_cnt !== 16'd2) begin errs++; $display("FAIL multi_pkt_cnt got=%0d exp=2", bus.pkt_cnt); end
    endtask

    task automatic test_no_match();
        int sc, so, sb, ss, ec;
        send_pkt(3, 64'h0, -1, sc, so, sb, ss, ec);
        drain(1'b0, 1'b0, 99);
        vec++; if (r_n !== 1) begin errs++; $display("FAIL none_nrec got=%0d exp=1", r_n); end
        vec++; if (r_none[0] !== 1'b1 || r_id[0] !== 6'd0 || r_last[0] !== 1'b1) begin errs++;
            $display("FAIL none_rec got none=%0b id=%0d last=%0b exp none=1 id=0 last=1", r_none[0], r_id[0], r_last[0]); end
        vec++; if (bus.pkt_cnt !== 16'd3) begin errs++; $display("FAIL none_pkt_cnt got=%0d exp=3", bus.pkt_cnt); end
    endtask

    task automatic test_stall_queued();
        int sc, so, sb, ss, ec, h;
        send_pkt(6, 64'h10, 3, sc, so, sb, ss, ec);
        vec++; if (ss !== 1 || sb !== 0) begin errs++; $display("FAIL stall_en got seen=%0d bad=%0d exp seen=1 bad=0", ss, sb); end
        drain(1'b0, 1'b1, 99);
        h = r_lasths;
        vec++; if (r_n !== 1 || r_id[0] !== 6'd4) begin errs++; $display("FAIL stall_rec got n=%0d id=%0d exp n=1 id=4", r_n, r_id[0]); end
        vec++; if (r_brbad !== 0) begin errs++; $display("FAIL queued_drain_ready got=%0d exp=0", r_brbad); end
        @(negedge clk);
        vec++; if (bus.byte_ready !== 1'b0 || bus.eng_sod !== 1'b0) begin errs++;
            $display("FAIL queued_t1 got ready=%0b sod=%0b exp 0 0", bus.byte_ready, bus.eng_sod); end
        tick();
        @(negedge clk);
        vec++; if (bus.byte_ready !== 1'b0 || bus.eng_sod !== 1'b1) begin errs++;
            $display("FAIL queued_t2 got ready=%0b sod=%0b exp 0 1", bus.byte_ready, bus.eng_sod); end
        tick();
        @(negedge clk);
        vec++; if (bus.byte_ready !== 1'b1 || bus.eng_en !== 1'b1 || cyc - h !== 3) begin errs++;
            $display("FAIL queued_t3 got ready=%0b en=%0b dt=%0d exp 1 1 3", bus.byte_ready, bus.eng_en, cyc - h); end
        ec = cyc;
        tick();
        bus.byte_valid = 1'b0; bus.byte_sop = 1'b0; bus.byte_eop = 1'b0;
        bus.eng_match = 64'h1;
        drain(1'b0, 1'b0, 99);
        vec++; if (r_n !== 1 || r_id[0] !== 6'd0 || r_none[0] !== 1'b0) begin errs++;
            $display("FAIL onebyte_rec got n=%0d id=%0d none=%0b exp 1 0 0", r_n, r_id[0], r_none[0]); end
        vec++; if (r_first - ec !== 4) begin errs++; $display("FAIL onebyte_latency got=%0d exp=4", r_first - ec); end
        vec++; if (bus.pkt_cnt !== 16'd5) begin errs++; $display("FAIL stall_pkt_cnt got=%0d exp=5", bus.pkt_cnt); end
        bus.byte_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vec++; if (bus.byte_ready !== 1'b1 || bus.eng_en !== 1'b0 || bus.eng_sod !== 1'b0) begin errs++;
                $display("FAIL idle_discard_%0d got ready=%0b en=%0b sod=%0b exp 1 0 0", k, bus.byte_ready, bus.eng_en, bus.eng_sod); end
            tick();
        end
        bus.byte_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_drain();
        int sc, so, sb, ss, ec;
        send_pkt(4, 64'hE, -1, sc, so, sb, ss, ec);
        drain(1'b0, 1'b0, 1);
        vec++; if (r_n !== 1 || r_id[0] !== 6'd1) begin errs++; $display("FAIL mid_first got n=%0d id=%0d exp 1 1", r_n, r_id[0]); end
        @(negedge clk);
        vec++; if (bus.rpt_valid !== 1'b1 || bus.rpt_id !== 6'd2 || bus.rpt_last !== 1'b0) begin errs++;
            $display("FAIL mid_second got v=%0b id=%0d last=%0b exp 1 2 0", bus.rpt_valid, bus.rpt_id, bus.rpt_last); end
        vec++; if (bus.pkt_cnt !== 16'd5) begin errs++; $display("FAIL mid_pkt_cnt got=%0d exp=5", bus.pkt_cnt); end
        #2;
        rst = 1'b1;
        #1;
        vec++; if (bus.rpt_valid !== 1'b0) begin errs++; $display("FAIL mid_async_valid got=%0b exp=0", bus.rpt_valid); end
        tick(); tick();
        rst = 1'b0;
        vec++; if (bus.pkt_cnt !== 16'd0) begin errs++; $display("FAIL mid_rst_pkt_cnt got=%0d exp=0", bus.pkt_cnt); end
        tick();
        send_pkt(3, 64'h100, -1, sc, so, sb, ss, ec);
        drain(1'b0, 1'b0, 99);
        vec++; if (r_n !== 1 || r_id[0] !== 6'd8 || r_last[0] !== 1'b1) begin errs++;
            $display("FAIL post_rst_rec got n=%0d id=%0d last=%0b exp 1 8 1", r_n, r_id[0], r_last[0]); end
        vec++; if (bus.pkt_cnt !== 16'd1) begin errs++; $display("FAIL post_rst_pkt_cnt got=%0d exp=1", bus.pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_bp();
        test_no_match();
        test_stall_queued();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
